// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master types and CSR bit positions
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } spi_state_t;

  localparam int SPI_CLK_DIV_DEFAULT = 4;

  // Bit positions inside the load/store unit's SPI CSR.
  localparam int SPI_CSR_BUSY_BIT = 0;
  localparam int SPI_CSR_CS_BIT   = 2;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - command/response handshake between load/store unit and SPI master
interface spi_master_if;

  logic       spi_trigger;
  logic [7:0] spi_command;
  logic       spi_cs_ctrl;
  logic       spi_busy;
  logic [7:0] spi_response;

  modport master (
    output spi_trigger, spi_command, spi_cs_ctrl,
    input  spi_busy, spi_response
  );

  modport slave (
    input  spi_trigger, spi_command, spi_cs_ctrl,
    output spi_busy, spi_response
  );

endinterface

// File: rtl/spi_miso_sync.sv
// rtl/spi_miso_sync.sv - two-flop MISO synchronizer, async active-high reset to 0
module spi_miso_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide mode-0 MSB-first SPI master for the load/store unit CSR
// Optional build macro SPI_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  lsu,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic miso_s;

`ifdef SPI_MISO_SYNC_EN
  // Sample two cycles into the high half so the synchronized bit has arrived.
  localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(2);

  if (CLK_DIV < 3) begin : g_div_chk
    $error("spi_master: CLK_DIV must be >= 3 when SPI_MISO_SYNC_EN is defined");
  end

  spi_miso_sync u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d_i (spi_miso),
    .q_o (miso_s)
  );
`else
  localparam logic [DIV_W-1:0] SAMPLE_AT = '0;

  if (CLK_DIV < 1) begin : g_div_chk
    $error("spi_master: CLK_DIV must be >= 1");
  end

  assign miso_s = spi_miso;
`endif

  spi_state_t       state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [6:0]       tx_q;
  logic [7:0]       rx_q;
  logic [7:0]       rx_d;
  logic             sclk_q;
  logic             mosi_q;
  logic             busy_q;
  logic [7:0]       resp_q;

  // With CLK_DIV=1 the sample point coincides with the terminal count, so the
  // response must be taken from the post-sample value.
  always_comb begin
    rx_d = rx_q;
    if (state_q == HIGH && div_q == SAMPLE_AT) begin
      rx_d = {rx_q[6:0], miso_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 7'd0;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      resp_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          if (lsu.spi_trigger) begin
            tx_q    <= lsu.spi_command[6:0];
            mosi_q  <= lsu.spi_command[7];
            busy_q  <= 1'b1;
            bit_q   <= 3'd0;
            div_q   <= '0;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (div_q == DIV_LAST) begin
            sclk_q  <= 1'b1;
            div_q   <= '0;
            state_q <= HIGH;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        HIGH: begin
          rx_q <= rx_d;
          if (div_q == DIV_LAST) begin
            sclk_q <= 1'b0;
            div_q  <= '0;
            if (bit_q == 3'd7) begin
              resp_q  <= rx_d;
              busy_q  <= 1'b0;
              mosi_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              mosi_q  <= tx_q[6];
              tx_q    <= {tx_q[5:0], 1'b0};
              bit_q   <= bit_q + 3'd1;
              state_q <= LOW;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_sclk         = sclk_q;
  assign spi_mosi         = mosi_q;
  assign spi_cs_n         = lsu.spi_cs_ctrl;
  assign lsu.spi_busy     = busy_q;
  assign lsu.spi_response = resp_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master against a byte-level model
module tb_spi_master;
  import spi_pkg::*;

`ifdef SPI_MISO_SYNC_EN
  localparam int DIV = 3;
`else
  localparam int DIV = SPI_CLK_DIV_DEFAULT;
`endif
  localparam int XFER_CYC = 16 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_cs_n;

  spi_master_if lsu_if ();

  spi_master #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .lsu      (lsu_if),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Free-running observers of the serial pins.
  int         rises_total = 0;
  int         falls_total = 0;
  logic [7:0] mosi_hist   = 8'h00;

  always @(posedge spi_sclk) begin
    rises_total <= rises_total + 1;
    mosi_hist   <= {mosi_hist[6:0], spi_mosi};
  end

  always @(negedge spi_sclk) falls_total <= falls_total + 1;

  // Mode-0 slave: presents its MSB before the first rise, advances on each fall.
  logic       loop_en    = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         falls_base = 0;
  int         slave_k;

  assign slave_k  = (falls_total - falls_base > 7) ? 7 : (falls_total - falls_base);
  assign spi_miso = loop_en ? spi_mosi : slave_byte[3'(7 - slave_k)];

  task automatic run_xfer(input logic [7:0] cmd, input logic lp, input logic [7:0] sb,
                          input string tag);
    int t;
    int cyc;
    int r0;
    int k;
    int mosi_err;
    int late;
    logic [7:0] exp_resp;
    exp_resp = lp ? cmd : sb;
    lsu_if.spi_command = cmd;
    loop_en    = lp;
    slave_byte = sb;
    falls_base = falls_total;
    r0         = rises_total;
    lsu_if.spi_trigger = 1'b1;
    t = 0;
    @(negedge clk);
    while (!lsu_if.spi_busy && t < 8) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_accept"}, 32'(lsu_if.spi_busy), 32'd1);
    lsu_if.spi_trigger = 1'b0;
    lsu_if.spi_command = ~cmd;
    cyc = 0;
    mosi_err = 0;
    while (lsu_if.spi_busy && cyc < XFER_CYC + 8) begin
      cyc++;
      k = (falls_total - falls_base > 7) ? 7 : (falls_total - falls_base);
      if (spi_mosi !== cmd[3'(7 - k)]) mosi_err++;
      if (cyc == 5 * DIV) lsu_if.spi_trigger = 1'b1;
      if (cyc == 5 * DIV + 3) lsu_if.spi_trigger = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(cyc), 32'(XFER_CYC));
    check({tag, "_sclk_rises"}, 32'(rises_total - r0), 32'd8);
    check({tag, "_mosi_bits"}, 32'(mosi_hist), 32'(cmd));
    check({tag, "_mosi_stable"}, 32'(mosi_err), 32'd0);
    check({tag, "_response"}, 32'(lsu_if.spi_response), 32'(exp_resp));
    check({tag, "_idle_mosi"}, 32'(spi_mosi), 32'd0);
    late = 0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_if.spi_busy) late++;
    end
    check({tag, "_no_retrigger"}, 32'(late), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int cyc;
    int r0;
    logic [7:0] c;
    logic       lp;
    logic [7:0] sb;

    rst = 1'b1;
    lsu_if.spi_trigger = 1'b0;
    lsu_if.spi_command = 8'h00;
    lsu_if.spi_cs_ctrl = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy", 32'(lsu_if.spi_busy), 32'd0);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_response", 32'(lsu_if.spi_response), 32'h00);
    check("cs_pass_hi", 32'(spi_cs_n), 32'd1);
    lsu_if.spi_cs_ctrl = 1'b0;
    #1;
    check("cs_pass_lo", 32'(spi_cs_n), 32'd0);

    // Abort: async reset right after the 4th SCLK rise of an 8'h81 transfer.
    lsu_if.spi_command = 8'h81;
    loop_en    = 1'b1;
    falls_base = falls_total;
    r0         = rises_total;
    lsu_if.spi_trigger = 1'b1;
    @(negedge clk);
    lsu_if.spi_trigger = 1'b0;
    t = 0;
    while (rises_total - r0 < 4 && t < XFER_CYC) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_sclk_high", 32'(spi_sclk), 32'd1);
    lsu_if.spi_cs_ctrl = 1'b1;
    #1;
    check("cs_midxfer", 32'(spi_cs_n), 32'd1);
    check("cs_no_abort", 32'(lsu_if.spi_busy), 32'd1);
    lsu_if.spi_cs_ctrl = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(lsu_if.spi_busy), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    check("abort_response", 32'(lsu_if.spi_response), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(8'h55, 1'b1, 8'h00, "post_abort");

    run_xfer(8'hA5, 1'b1, 8'h00, "loop_a5");
    run_xfer(8'hFF, 1'b0, 8'h3C, "drive_3c");
    run_xfer(8'h00, 1'b0, 8'hFF, "drive_ff");
    run_xfer(8'h01, 1'b0, 8'h80, "edge_bits");

    for (int i = 0; i < 16; i++) begin
      c  = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      sb = 8'($urandom);
      run_xfer(c, lp, sb, $sformatf("rand%0d", i));
    end

    // Trigger held through completion: back-to-back transfer one cycle later.
    lsu_if.spi_command = 8'h5A;
    loop_en = 1'b1;
    lsu_if.spi_trigger = 1'b1;
    t = 0;
    @(negedge clk);
    while (!lsu_if.spi_busy && t < 8) begin
      @(negedge clk);
      t++;
    end
    cyc = 0;
    while (lsu_if.spi_busy && cyc < XFER_CYC + 8) begin
      cyc++;
      @(negedge clk);
    end
    check("b2b_first_len", 32'(cyc), 32'(XFER_CYC));
    check("b2b_first_resp", 32'(lsu_if.spi_response), 32'h5A);
    @(negedge clk);
    check("b2b_restart", 32'(lsu_if.spi_busy), 32'd1);
    lsu_if.spi_trigger = 1'b0;
    lsu_if.spi_command = 8'h00;
    cyc = 0;
    while (lsu_if.spi_busy && cyc < XFER_CYC + 8) begin
      cyc++;
      @(negedge clk);
    end
    check("b2b_second_len", 32'(cyc), 32'(XFER_CYC));
    check("b2b_second_resp", 32'(lsu_if.spi_response), 32'h5A);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master (mode 0, MSB first) that serves the load/store unit's SPI command register. Accepts `spi_trigger`/`spi_command` from the load/store unit, shifts one byte out on MOSI while shifting one byte in from MISO, then presents `spi_response`. Drives `spi_busy` back as bit 0 of the SPI CSR. The load/store unit clears its trigger on that bit, which closes the handshake. Sits between the load/store unit and the board SPI pins.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range ≥1, and ≥3 when `SPI_MISO_SYNC_EN` is defined.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `spi_trigger`  in  1  transfer request level from the load/store unit.
- `spi_command`  in  8  byte to transmit; sampled on accept.
- `spi_cs_ctrl`  in  1  software chip-select bit (SPI CSR bit 2), 1 = deselected.
- `spi_busy`  out  1  transfer in progress; wired to SPI CSR bit 0.
- `spi_response`  out  8  last received byte; holds until the next transfer completes.
- `spi_sclk`  out  1  serial clock, idles low.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.
- `spi_cs_n`  out  1  pin chip-select = `spi_cs_ctrl`, passed straight through combinationally.

## Operation
- **Reset values:**
  - `spi_busy`=0, `spi_sclk`=0, `spi_mosi`=0, `spi_response`=8'h00.
  - State IDLE; all counters 0.
- **States:**
  - IDLE: `spi_sclk`=0, `spi_busy`=0.
  - LOW: SCLK low half.
  - HIGH: SCLK high half.
- **IDLE → LOW** when `spi_trigger`=1 at a clock edge:
  - load tx shift reg ← `spi_command`;
  - `spi_mosi` ← `spi_command[7]`;
  - `spi_busy` ← 1; bit counter ← 0; divider ← 0.
- **Trigger handling:**
  - Trigger is level-sensitive and is only examined in IDLE.
  - Trigger while busy is ignored; the load/store unit drops writes made during busy.
- **LOW:** divider counts 0..`CLK_DIV`-1. At terminal count: `spi_sclk` ← 1, go to HIGH, divider ← 0.
- **HIGH:**
  - MISO is sampled into the rx shift reg LSB at the sample point (see Configuration).
  - At terminal count, if bit counter < 7:
    - `spi_sclk` ← 0; tx shift left; `spi_mosi` ← next bit; bit counter +1; go to LOW.
  - At terminal count, if bit counter = 7:
    - `spi_sclk` ← 0; `spi_response` ← rx reg; `spi_busy` ← 0; `spi_mosi` ← 0; go to IDLE.
- **Counter widths:**
  - Divider is `$clog2(CLK_DIV)` bits (minimum 1). Bit counter is 3 bits; no wrap beyond 7 is used.
- **Response:** `spi_response` updates only on completion; it never shows a partial byte.
- **Chip select:** CS is not sequenced by this block. Toggling `spi_cs_ctrl` mid-transfer changes `spi_cs_n` immediately and does not abort the shift.
- **Reset mid-transfer:** immediate return to the reset values; the partial byte is discarded.

## Timing
- Accept edge to `spi_busy` high: same edge (registered output, visible the cycle after trigger is seen).
- Transfer length: `spi_busy` is high for exactly 16·`CLK_DIV` cycles.
- With `CLK_DIV`=4: 64 cycles, SCLK period 8 cycles, 8 rising edges.
- `spi_response` becomes valid on the same edge that `spi_busy` falls.
- Earliest next accept is the following edge, if the trigger is high again.
- MOSI changes only on SCLK falling transitions (and at accept), so it is stable through every rising edge.

## Configuration
- **`SPI_MISO_SYNC_EN` defined:**
  - MISO passes through a 2-flop synchronizer.
  - The sample point is the HIGH-state cycle with divider = 2, i.e. two cycles after SCLK rises, compensating the synchronizer delay.
  - `CLK_DIV` must be ≥3; elaboration fails otherwise.
- **Not defined:**
  - MISO is sampled raw at the first HIGH-state cycle (divider = 0).
  - `CLK_DIV` ≥1.
- Transfer length and handshake timing are identical in both builds.

## Structure
- **Package `spi_pkg`:**
  - state enum `spi_state_t` {IDLE, LOW, HIGH};
  - `SPI_CLK_DIV_DEFAULT` = 4;
  - CSR bit-index constants `SPI_CSR_BUSY_BIT` = 0 and `SPI_CSR_CS_BIT` = 2, shared with the load/store unit.
- **Sub-module `spi_miso_sync`:** 2-flop synchronizer with async active-high reset to 0. Instantiated only under `SPI_MISO_SYNC_EN`.

## Test plan
- **Reset:** reset asserted asynchronously mid-cycle → all outputs at reset values immediately; `spi_sclk`=0, `spi_busy`=0, `spi_response`=8'h00.
- **Loopback:** `CLK_DIV`=4, MISO tied to MOSI, trigger with command 8'hA5 → MOSI bits 1,0,1,0,0,1,0,1; 8 SCLK pulses; busy high 64 cycles; `spi_response`=8'hA5.
- **Driven MISO:** slave model drives 8'h3C while master sends 8'hFF → `spi_response`=8'h3C; MOSI constant 1 during the transfer.
- **Handshake:** trigger held high until busy is seen, then dropped → exactly one transfer. Trigger re-pulsed while busy → no second transfer. Trigger held high through completion → a second transfer starts the cycle after busy falls.
- **Abort:** reset asserted at the 4th SCLK rise with command 8'h81 → `spi_sclk`=0, `spi_busy`=0, `spi_response` unchanged at 8'h00. A next transfer of 8'h55 in loopback → 8'h55.
- **Sync build:** `SPI_MISO_SYNC_EN` defined, `CLK_DIV`=3, loopback command 8'hC3 → `spi_response`=8'hC3, busy high 48 cycles. `CLK_DIV`=2 → elaboration error.
